// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared types and weight-add helper; PERCEPTRON_SATURATE_EN clamps weight updates.
package perceptron_pkg;
    typedef logic signed [13:0] weight_t;
    typedef logic signed [6:0] sample_t;
    typedef logic [1:0] label_t;
    typedef enum logic [2:0] {IDLE, FETCH, CALC, UPDATE, EPOCH_END, DONE} state_t;
    localparam int FRAC_SHIFT = 4;
    localparam label_t LABEL_POS = 2'b01;
    localparam label_t LABEL_NEG = 2'b11;
    function automatic weight_t add_w(input weight_t a, input weight_t d, input logic neg);
`ifdef PERCEPTRON_SATURATE_EN
        logic signed [14:0] s;
        s = neg ? $signed({a[13], a}) - $signed({d[13], d}) : $signed({a[13], a}) + $signed({d[13], d});
        return (s[14] != s[13]) ? {s[14], {13{~s[14]}}} : s[13:0];
`else
        return neg ? a - d : a + d;
`endif
    endfunction
endpackage

// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if: labelled-sample stream feeding the trainer.
interface perceptron_trainer_if;
    import perceptron_pkg::*;
    logic in_valid, in_ready, in_last;
    sample_t x1, x2;
    label_t t;
    modport master (output in_valid, x1, x2, t, in_last, input in_ready);
    modport slave (input in_valid, x1, x2, t, in_last, output in_ready);
endinterface

// File: rtl/perceptron_dot.sv
// perceptron_dot: 14b wrapped b + x1*w1 + x2*w2 and its sign as a label, shared with the test stage.
module perceptron_dot
    import perceptron_pkg::*;
(
    input  sample_t x1, x2,
    input  weight_t w1, w2, b,
    output weight_t sum,
    output label_t  y
);
    logic signed [20:0] p1, p2;
    always_comb begin
        p1 = 21'(x1) * 21'(w1);
        p2 = 21'(x2) * 21'(w2);
        sum = b + 14'(p1 >>> FRAC_SHIFT) + 14'(p2 >>> FRAC_SHIFT);
        y = sum[13] ? LABEL_NEG : LABEL_POS;
    end
endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: epoch-by-epoch perceptron training of w1/w2/b; build option PERCEPTRON_SATURATE_EN.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int      MAX_EPOCHS = 100,
    parameter weight_t ETA        = 14'sd16,
    parameter weight_t INIT_W1    = '0,
    parameter weight_t INIT_W2    = '0,
    parameter weight_t INIT_B     = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    perceptron_trainer_if.slave s_if,
    output weight_t w1, w2, b,
    output logic en,
    output logic converged,
    output logic [7:0] epoch_cnt
);
    state_t state_q, state_d;
    weight_t w1_q, w1_d, w2_q, w2_d, b_q, b_d, d1, d2, sum_unused;
    sample_t x1_q, x1_d, x2_q, x2_d;
    label_t t_q, t_d, y_q, y_d, y;
    logic last_q, last_d, conv_q, conv_d;
    logic [7:0] err_q, err_d, epoch_q, epoch_d;
    logic signed [20:0] e1, e2;

    perceptron_dot u_dot (.x1(x1_q), .x2(x2_q), .w1(w1_q), .w2(w2_q), .b(b_q), .sum(sum_unused), .y(y));

    always_comb begin
        e1 = 21'(x1_q) * 21'(ETA);
        e2 = 21'(x2_q) * 21'(ETA);
        d1 = 14'(e1 >>> FRAC_SHIFT);
        d2 = 14'(e2 >>> FRAC_SHIFT);
        state_d = state_q;
        w1_d = w1_q;
        w2_d = w2_q;
        b_d = b_q;
        x1_d = x1_q;
        x2_d = x2_q;
        t_d = t_q;
        last_d = last_q;
        y_d = y_q;
        conv_d = conv_q;
        err_d = err_q;
        epoch_d = epoch_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = FETCH;
                w1_d = INIT_W1;
                w2_d = INIT_W2;
                b_d = INIT_B;
                conv_d = 1'b0;
                err_d = '0;
                epoch_d = '0;
            end
            FETCH: if (s_if.in_valid) begin
                state_d = CALC;
                x1_d = s_if.x1;
                x2_d = s_if.x2;
                t_d = s_if.t;
                last_d = s_if.in_last;
            end
            CALC: begin
                state_d = UPDATE;
                y_d = y;
            end
            UPDATE: begin
                state_d = last_q ? EPOCH_END : FETCH;
                // t[1] selects subtraction for a -1 label
                if (y_q != t_q) begin
                    w1_d = add_w(w1_q, d1, t_q[1]);
                    w2_d = add_w(w2_q, d2, t_q[1]);
                    b_d = add_w(b_q, ETA, t_q[1]);
                    err_d = err_q + 8'(err_q != 8'hff);
                end
            end
            EPOCH_END: begin
                epoch_d = epoch_q + 8'(epoch_q != 8'hff);
                conv_d = err_q == '0;
                state_d = (conv_d || {1'b0, epoch_q} + 9'd1 == 9'(MAX_EPOCHS)) ? DONE : FETCH;
                err_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w1_q <= INIT_W1;
            w2_q <= INIT_W2;
            b_q <= INIT_B;
            x1_q <= '0;
            x2_q <= '0;
            t_q <= LABEL_POS;
            last_q <= 1'b0;
            y_q <= LABEL_POS;
            conv_q <= 1'b0;
            err_q <= '0;
            epoch_q <= '0;
        end else begin
            state_q <= state_d;
            w1_q <= w1_d;
            w2_q <= w2_d;
            b_q <= b_d;
            x1_q <= x1_d;
            x2_q <= x2_d;
            t_q <= t_d;
            last_q <= last_d;
            y_q <= y_d;
            conv_q <= conv_d;
            err_q <= err_d;
            epoch_q <= epoch_d;
        end
    end

    assign s_if.in_ready = state_q == FETCH;
    assign en = state_q == DONE;
    assign converged = conv_q;
    assign epoch_cnt = epoch_q;
    assign w1 = w1_q;
    assign w2 = w2_q;
    assign b = b_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed checks of three trainer instances (default, 4-epoch limit, near-overflow init).
module tb_perceptron_trainer;
    import perceptron_pkg::*;
`ifdef PERCEPTRON_SATURATE_EN
    localparam int OVF_W1 = 8191;
`else
    localparam int OVF_W1 = -8188;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    sample_t x1 = '0, x2 = '0;
    label_t t = LABEL_POS;
    int sel = 0, vecs = 0, errs = 0;
    logic rdy, cur_en;
    weight_t a_w1, a_w2, a_b, x_w1, x_w2, x_b, s_w1, s_w2, s_b;
    logic a_en, a_cv, x_en, x_cv, s_en, s_cv;
    logic [7:0] a_ep, x_ep, s_ep;

    perceptron_trainer_if if_a(), if_x(), if_s();

    assign if_a.in_valid = in_valid && sel == 0;
    assign if_x.in_valid = in_valid && sel == 1;
    assign if_s.in_valid = in_valid && sel == 2;
    assign {if_a.x1, if_a.x2, if_a.t, if_a.in_last} = {x1, x2, t, in_last};
    assign {if_x.x1, if_x.x2, if_x.t, if_x.in_last} = {x1, x2, t, in_last};
    assign {if_s.x1, if_s.x2, if_s.t, if_s.in_last} = {x1, x2, t, in_last};
    assign rdy = sel == 0 ? if_a.in_ready : sel == 1 ? if_x.in_ready : if_s.in_ready;
    assign cur_en = sel == 0 ? a_en : sel == 1 ? x_en : s_en;

    perceptron_trainer u_a (.clk(clk), .rst(rst), .start(start && sel == 0), .s_if(if_a),
        .w1(a_w1), .w2(a_w2), .b(a_b), .en(a_en), .converged(a_cv), .epoch_cnt(a_ep));
    perceptron_trainer #(.MAX_EPOCHS(4)) u_x (.clk(clk), .rst(rst), .start(start && sel == 1), .s_if(if_x),
        .w1(x_w1), .w2(x_w2), .b(x_b), .en(x_en), .converged(x_cv), .epoch_cnt(x_ep));
    perceptron_trainer #(.INIT_W1(14'sd8180), .INIT_B(weight_t'(-8192))) u_s (.clk(clk), .rst(rst),
        .start(start && sel == 2), .s_if(if_s),
        .w1(s_w1), .w2(s_w2), .b(s_b), .en(s_en), .converged(s_cv), .epoch_cnt(s_ep));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic send(input int a, input int c, input label_t lab, input logic last);
        int n = 0;
        @(negedge clk);
        x1 = 7'(a);
        x2 = 7'(c);
        t = lab;
        in_last = last;
        in_valid = 1'b1;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("handshake", int'(n < 50), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic settle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!rdy && !cur_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(n < 20), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_a_w1", a_w1, 0);
        chk("rst_a_b", a_b, 0);
        chk("rst_a_en", a_en, 0);
        chk("rst_a_rdy", if_a.in_ready, 0);
        chk("rst_a_ep", a_ep, 0);
        chk("rst_a_cv", a_cv, 0);
        chk("rst_s_w1", s_w1, 8180);
        chk("rst_s_b", s_b, -8192);
        chk("rst_x_en", x_en, 0);
        rst = 1'b0;

        sel = 0;
        pulse_start();
        chk("start_rdy", rdy, 1);
        send(16, 0, LABEL_NEG, 1'b0);
        settle("upd_settle");
        chk("upd_w1", a_w1, -16);
        chk("upd_w2", a_w2, 0);
        chk("upd_b", a_b, -16);
        chk("upd_ep", a_ep, 0);
        pulse_start();
        chk("ign_start_w1", a_w1, -16);
        chk("ign_start_rdy", rdy, 1);
        repeat (5) @(negedge clk);
        chk("idle_valid_rdy", rdy, 1);
        chk("idle_valid_b", a_b, -16);
        pulse_rst();

        pulse_start();
        for (int e = 0; e < 10 && !a_en; e++) begin
            send(0, 0, LABEL_NEG, 1'b0);
            send(0, 16, LABEL_NEG, 1'b0);
            send(16, 0, LABEL_NEG, 1'b0);
            send(16, 16, LABEL_POS, 1'b1);
            settle("and_epoch");
        end
        chk("and_en", a_en, 1);
        chk("and_cv", a_cv, 1);
        chk("and_ep", a_ep, 6);
        chk("and_w1", a_w1, 32);
        chk("and_w2", a_w2, 16);
        chk("and_b", a_b, -48);
        chk("and_rdy", rdy, 0);

        sel = 1;
        pulse_start();
        for (int e = 0; e < 10 && !x_en; e++) begin
            send(0, 0, LABEL_NEG, 1'b0);
            send(0, 16, LABEL_POS, 1'b0);
            send(16, 0, LABEL_POS, 1'b0);
            send(16, 16, LABEL_NEG, 1'b1);
            settle("xor_epoch");
        end
        chk("xor_en", x_en, 1);
        chk("xor_cv", x_cv, 0);
        chk("xor_ep", x_ep, 4);

        sel = 0;
        pulse_start();
        chk("restart_en", a_en, 0);
        chk("restart_cv", a_cv, 0);
        chk("restart_ep", a_ep, 0);
        chk("restart_w1", a_w1, 0);
        chk("restart_rdy", rdy, 1);

        sel = 2;
        pulse_start();
        send(16, 0, LABEL_POS, 1'b1);
        settle("ovf_settle");
        chk("ovf_w1", s_w1, OVF_W1);
        chk("ovf_w2", s_w2, 0);
        chk("ovf_b", s_b, -8176);
        chk("ovf_ep", s_ep, 1);
        chk("ovf_en", s_en, 0);

        sel = 0;
        x1 = 7'sd16;
        x2 = 7'sd16;
        t = LABEL_NEG;
        in_last = 1'b0;
        repeat (12) @(negedge clk) in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_w1", a_w1, 0);
        chk("mid_rst_w2", a_w2, 0);
        chk("mid_rst_b", a_b, 0);
        chk("mid_rst_rdy", if_a.in_ready, 0);
        chk("mid_rst_en", a_en, 0);
        chk("mid_rst_ep", a_ep, 0);
        chk("mid_rst_s_w1", s_w1, 8180);
        chk("mid_rst_x_en", x_en, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_start_rdy", if_a.in_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
